// File: rtl/apb_slave_regfile_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB completer register file and its agent /
// scoreboard: default bus widths, default register count and the completer
// FSM state encoding.
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W      = 8;
  localparam int APB_DATA_W      = 8;
  localparam int APB_DEPTH       = 64;
  localparam int APB_MAX_WAIT    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } apb_slv_state_e;

endpackage : apb_pkg

// File: rtl/apb_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// apb_if
// APB bus bundle between a requester (master) and a completer (slave).
//   psel, penable, pwrite, paddr, pwdata : requester -> completer
//   prdata, pready, pslverr              : completer -> requester
// Clock and reset are kept as plain ports on the attached modules.
// -----------------------------------------------------------------------------
interface apb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface : apb_if

// File: rtl/apb_slave_regfile_regbank.sv
// -----------------------------------------------------------------------------
// apb_slv_regbank
// DEPTH x DATA_W register array with one synchronous write port and one
// combinational read port. Every entry resets asynchronously to RESET_VAL.
//   clk, rst_n          : clock, async active-low reset
//   we, waddr, wdata    : write port (takes effect on rising clk)
//   raddr, rdata        : combinational read port
// -----------------------------------------------------------------------------
module apb_slv_regbank #(
  parameter int                DEPTH     = 64,
  parameter int                DATA_W    = 8,
  parameter int                IDX_W     = 6,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs_q [DEPTH];

  // NOTE: this bank is a register file with a defined reset value, so every
  // entry is reset; a RAM macro without reset could not be used here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata = regs_q[raddr];

endmodule : apb_slv_regbank

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB completer with a configurable number of access-phase wait states in
// front of a DEPTH-entry byte register bank. Out-of-range addresses complete
// with pslverr and never touch the bank.
//   pclk, presetn : bus clock, async active-low reset
//   bus (slave)   : psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out
// -----------------------------------------------------------------------------
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = APB_ADDR_W,
  parameter int                DATA_W      = APB_DATA_W,
  parameter int                DEPTH       = APB_DEPTH,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic pclk,
  input  logic presetn,
  apb_if.slave bus
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_slv_state_e    state_q,  state_d;
  logic [3:0]        cnt_q,    cnt_d;
  logic [IDX_W-1:0]  addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              write_q,  write_d;
  logic              err_q,    err_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic              setup_seen;
  logic              access_seen;
  logic              in_range;
  logic              bank_we;
  logic [DATA_W-1:0] bank_rdata;

  assign setup_seen  = bus.psel && !bus.penable;
  assign access_seen = bus.psel &&  bus.penable;
  assign in_range    = 32'(bus.paddr) < 32'(DEPTH);

  // Read data is sampled straight off the live address during setup, so the
  // bank read port is driven by paddr rather than the latched address.
  apb_slv_regbank #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (bank_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (bus.paddr[IDX_W-1:0]),
    .rdata (bank_rdata)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    bank_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // penable already high without a setup cycle is not a transfer.
        if (setup_seen) begin
          addr_d  = bus.paddr[IDX_W-1:0];
          wdata_d = bus.pwdata;
          write_d = bus.pwrite;
          err_d   = !in_range;
          cnt_d   = WAIT_INIT;
          if (!bus.pwrite) prdata_d = in_range ? bank_rdata : '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!bus.psel)            state_d = IDLE;
        else if (cnt_q == 4'd1)   state_d = ACK;
        else                      cnt_d   = cnt_q - 4'd1;
      end
      ACK: begin
        if (access_seen) begin
          bank_we = write_q && !err_q;
          state_d = IDLE;
        end else if (!bus.psel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  assign bus.pready  = (state_q == ACK);
  assign bus.pslverr = (state_q == ACK) && err_q;
  assign bus.prdata  = prdata_q;

endmodule : apb_slave_regfile

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Directed bench for apb_slave_regfile: one instance with no wait states and
// one with two wait states, sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;
  import apb_pkg::*;

  logic pclk;
  logic presetn;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_if #(.ADDR_W(8), .DATA_W(8)) apb0 ();
  apb_if #(.ADDR_W(8), .DATA_W(8)) apb2 ();

  apb_slave_regfile #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0), .RESET_VAL(8'h00)
  ) u_dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (apb0.slave)
  );

  apb_slave_regfile #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2), .RESET_VAL(8'h00)
  ) u_dut2 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (apb2.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input int d, input logic s, input logic e, input logic w,
                         input logic [7:0] a, input logic [7:0] wd);
    if (d == 0) begin
      apb0.psel = s; apb0.penable = e; apb0.pwrite = w; apb0.paddr = a; apb0.pwdata = wd;
    end else begin
      apb2.psel = s; apb2.penable = e; apb2.pwrite = w; apb2.paddr = a; apb2.pwdata = wd;
    end
  endtask

  task automatic get_bus(input int d, output logic rdy, output logic err, output logic [7:0] rd);
    if (d == 0) begin
      rdy = apb0.pready; err = apb0.pslverr; rd = apb0.prdata;
    end else begin
      rdy = apb2.pready; err = apb2.pslverr; rd = apb2.prdata;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge with
  // the bus idle, so a following call is a back-to-back setup.
  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic err, output int waits);
    logic       rdy;
    logic       e;
    logic [7:0] r;
    set_bus(d, 1'b1, 1'b0, w, a, wd);
    @(posedge pclk); #1;
    set_bus(d, 1'b1, 1'b1, w, a, wd);
    waits = 0;
    rdy   = 1'b0;
    e     = 1'b0;
    r     = '0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      #1;
      get_bus(d, rdy, e, r);
      if (!rdy) begin
        check("slverr_without_ready", 32'(e), 32'd0);
        waits++;
        @(posedge pclk); #1;
      end
    end
    check("xfer_completed", 32'(rdy), 32'd1);
    rd  = r;
    err = e;
    @(posedge pclk); #1;
    set_bus(d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         waits;

    presetn = 1'b0;
    set_bus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_bus(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;

    // Reset state
    check("rst_pready0",  32'(apb0.pready),  32'd0);
    check("rst_pslverr0", 32'(apb0.pslverr), 32'd0);
    check("rst_prdata0",  32'(apb0.prdata),  32'd0);
    check("rst_pready2",  32'(apb2.pready),  32'd0);

    // Zero wait states: write then read back
    xfer(0, 1'b1, 8'h10, 8'h5A, rd, err, waits);
    check("w10_waits", 32'(waits), 32'd0);
    check("w10_err",   32'(err),   32'd0);
    xfer(0, 1'b0, 8'h10, 8'h00, rd, err, waits);
    check("r10_data",  32'(rd),    32'h5A);
    check("r10_err",   32'(err),   32'd0);
    check("r10_waits", 32'(waits), 32'd0);

    // Reset asserted mid-transfer while pready is high
    set_bus(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    @(posedge pclk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    check("pre_rst_pready", 32'(apb0.pready), 32'd1);
    check("pre_rst_prdata", 32'(apb0.prdata), 32'h5A);
    #1 presetn = 1'b0;
    #1;
    check("mid_rst_pready",  32'(apb0.pready),  32'd0);
    check("mid_rst_pslverr", 32'(apb0.pslverr), 32'd0);
    check("mid_rst_prdata",  32'(apb0.prdata),  32'd0);
    @(posedge pclk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(0, 1'b0, 8'h05, 8'h00, rd, err, waits);
    check("r05_after_rst", 32'(rd), 32'h00);
    xfer(0, 1'b0, 8'h10, 8'h00, rd, err, waits);
    check("r10_after_rst", 32'(rd), 32'h00);

    // Out-of-range address (DEPTH=64)
    xfer(0, 1'b1, 8'h40, 8'hFF, rd, err, waits);
    check("w40_err",   32'(err),   32'd1);
    check("w40_waits", 32'(waits), 32'd0);
    xfer(0, 1'b0, 8'h40, 8'h00, rd, err, waits);
    check("r40_data",  32'(rd),    32'h00);
    check("r40_err",   32'(err),   32'd1);
    xfer(0, 1'b0, 8'h00, 8'h00, rd, err, waits);
    check("r00_no_alias", 32'(rd),  32'h00);
    check("r00_err",      32'(err), 32'd0);

    // Two wait states: pready 0,0,1 and bank updates only on the third edge
    set_bus(2, 1'b1, 1'b0, 1'b1, 8'h20, 8'hC3);
    @(posedge pclk); #1;
    set_bus(2, 1'b1, 1'b1, 1'b1, 8'h20, 8'hC3);
    #1;
    check("c3_acc1_pready", 32'(apb2.pready), 32'd0);
    check("c3_acc1_reg",    32'(u_dut2.u_bank.regs_q[32]), 32'h00);
    @(posedge pclk); #2;
    check("c3_acc2_pready", 32'(apb2.pready), 32'd0);
    check("c3_acc2_reg",    32'(u_dut2.u_bank.regs_q[32]), 32'h00);
    @(posedge pclk); #2;
    check("c3_acc3_pready",  32'(apb2.pready),  32'd1);
    check("c3_acc3_pslverr", 32'(apb2.pslverr), 32'd0);
    check("c3_acc3_reg",     32'(u_dut2.u_bank.regs_q[32]), 32'h00);
    @(posedge pclk); #1;
    set_bus(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check("c3_after_reg",    32'(u_dut2.u_bank.regs_q[32]), 32'hC3);
    check("c3_after_pready", 32'(apb2.pready), 32'd0);
    xfer(2, 1'b0, 8'h20, 8'h00, rd, err, waits);
    check("r20_data",  32'(rd),    32'hC3);
    check("r20_waits", 32'(waits), 32'd2);

    // Abort during WAIT: psel dropped, no write
    xfer(2, 1'b1, 8'h08, 8'h11, rd, err, waits);
    check("w08_waits", 32'(waits), 32'd2);
    set_bus(2, 1'b1, 1'b0, 1'b1, 8'h08, 8'h77);
    @(posedge pclk); #1;
    set_bus(2, 1'b1, 1'b1, 1'b1, 8'h08, 8'h77);
    @(posedge pclk); #1;
    set_bus(2, 1'b0, 1'b0, 1'b1, 8'h08, 8'h77);
    @(posedge pclk); #1;
    check("abort_state",  32'(u_dut2.state_q), 32'(IDLE));
    check("abort_pready", 32'(apb2.pready),    32'd0);
    set_bus(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    xfer(2, 1'b0, 8'h08, 8'h00, rd, err, waits);
    check("r08_prior", 32'(rd), 32'h11);

    // Back-to-back transfers with no idle cycle
    xfer(0, 1'b1, 8'h03, 8'h01, rd, err, waits);
    xfer(0, 1'b0, 8'h03, 8'h00, rd, err, waits);
    check("b2b_r03_data",  32'(rd),    32'h01);
    check("b2b_r03_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 8'h04, 8'h99, rd, err, waits);
    check("prdata_held_over_write", 32'(apb0.prdata), 32'h01);
    xfer(0, 1'b0, 8'h04, 8'h00, rd, err, waits);
    check("r04_data", 32'(rd), 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_apb_slave_regfile
